hsid_x_obi_pixel_fetch: RTL and testbench

- OBI read master that streams one hyperspectral pixel vector from memory into the HSID datapath.
- Sits directly upstream of the OBI memory (the memory model in simulation, the bus in the SoC).
- On start it issues sequential word reads from base_addr and buffers responses in a small FIFO.
- Each 32-bit word is unpacked into two DATA_WIDTH pixel samples (LSB half first) on a valid/ready stream.

---
 rtl/hsid_x_obi_pixel_fetch_if.sv | 40 ++++
 rtl/hsid_x_obi_pixel_fetch.sv | 131 +++++++++++++
 tb/tb_hsid_x_obi_pixel_fetch.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hsid_x_obi_pixel_fetch_if.sv
// OBI request/response types and the bundle carrying the OBI bus and the
// pixel stream between the pixel fetcher and its neighbours.
package hsid_x_obi_inf_pkg;
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

interface hsid_x_obi_pixel_fetch_if #(
    parameter int DATA_WIDTH = 16
);
    import hsid_x_obi_inf_pkg::*;

    obi_req_t              obi_req;
    obi_resp_t             obi_rsp;
    logic                  pixel_valid;
    logic                  pixel_ready;
    logic [DATA_WIDTH-1:0] pixel_data;
    logic                  pixel_last;

    modport master (
        output obi_req, pixel_valid, pixel_data, pixel_last,
        input  obi_rsp, pixel_ready
    );

    modport slave (
        input  obi_req, pixel_valid, pixel_data, pixel_last,
        output obi_rsp, pixel_ready
    );
endinterface

// File: rtl/hsid_x_obi_pixel_fetch.sv
// OBI read master streaming one pixel vector: sequential word reads buffered
// in a small FIFO, each word split into two samples, LSB half first.
module hsid_x_obi_pixel_fetch
    import hsid_x_obi_inf_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  num_words,
    output logic                  busy,
    output logic                  done,
    hsid_x_obi_pixel_fetch_if.master bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    state_t state_q, state_n;

    logic [WORD_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q, issued_q, issued_n, rd_idx_q;
    logic [CW-1:0]         out_q, out_n, cnt_q, cnt_n;
    logic [PW-1:0]         wptr_q, rptr_q;
    logic                  req_q, req_n, half_q, last_seen_q;
    logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] head;
    logic                  hs, push, pop, pix_valid, pix_acc, is_last_word;

    assign hs           = req_q && bus.obi_rsp.gnt;
    // Responses arriving while idle are leftovers of an aborted transfer.
    assign push         = bus.obi_rsp.rvalid && (state_q != IDLE);
    assign pix_valid    = (cnt_q != '0);
    assign pix_acc      = pix_valid && bus.pixel_ready;
    assign pop          = pix_acc && half_q;
    assign is_last_word = (rd_idx_q == len_q - LEN_WIDTH'(1));
    assign head         = mem_q[rptr_q];

    assign out_n    = out_q + CW'(hs) - CW'(push);
    assign cnt_n    = cnt_q + CW'(push) - CW'(pop);
    assign issued_n = issued_q + LEN_WIDTH'(hs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        req_n   = 1'b0;
        case (state_q)
            IDLE:  if (start) state_n = (num_words == '0) ? DONE : FETCH;
            FETCH: begin
                // A pending request is held unchanged until granted.
                if (req_q && !bus.obi_rsp.gnt)
                    req_n = 1'b1;
                else
                    req_n = (issued_n < len_q) &&
                            (({1'b0, out_n} + {1'b0, cnt_n}) < DEPTH_C);
                if (issued_q == len_q) state_n = DRAIN;
            end
            DRAIN: if (cnt_q == '0 && out_q == '0 && last_seen_q) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            rd_idx_q    <= '0;
            out_q       <= '0;
            cnt_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            req_q       <= 1'b0;
            half_q      <= 1'b0;
            last_seen_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                addr_q      <= base_addr;
                len_q       <= num_words;
                issued_q    <= '0;
                rd_idx_q    <= '0;
                last_seen_q <= 1'b0;
            end
            if (hs) begin
                addr_q   <= addr_q + WORD_WIDTH'(4);
                issued_q <= issued_n;
            end
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop) begin
                rptr_q   <= rptr_q + PW'(1);
                rd_idx_q <= rd_idx_q + LEN_WIDTH'(1);
                if (is_last_word) last_seen_q <= 1'b1;
            end
            if (pix_acc) half_q <= ~half_q;
            out_q <= out_n;
            cnt_q <= cnt_n;
            req_q <= req_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= bus.obi_rsp.rdata;
    end

    assert property (@(posedge clk) disable iff (rst) !(push && ({1'b0, cnt_q} == DEPTH_C)));

    assign bus.obi_req.req   = req_q;
    assign bus.obi_req.addr  = addr_q;
    assign bus.obi_req.we    = 1'b0;
    assign bus.obi_req.be    = 4'hF;
    assign bus.obi_req.wdata = '0;

    assign bus.pixel_valid = pix_valid;
    assign bus.pixel_data  = !pix_valid ? '0 :
                             half_q ? head[WORD_WIDTH-1:DATA_WIDTH] : head[DATA_WIDTH-1:0];
    assign bus.pixel_last  = pix_valid && half_q && is_last_word;

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
endmodule

// File: tb/tb_hsid_x_obi_pixel_fetch.sv
// Directed bench for the OBI pixel fetcher: memory model with fixed or random
// grant, monitor collecting handshakes/pixels, one task per scenario.
module tb_hsid_x_obi_pixel_fetch;
    import hsid_x_obi_inf_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] num_words = '0;
    logic        busy, done;
    logic        gnt = 1'b1, rvalid = 1'b0, pixel_ready = 1'b1;
    logic [31:0] rdata = '0;
    bit          random_gnt = 1'b0, def_gnt = 1'b1, inject = 1'b0;
    int          ncmp = 0, nfail = 0;

    hsid_x_obi_pixel_fetch_if #(.DATA_WIDTH(16)) bus ();

    assign bus.obi_rsp     = '{gnt: gnt, rvalid: rvalid, rdata: rdata};
    assign bus.pixel_ready = pixel_ready;

    hsid_x_obi_pixel_fetch #(
        .WORD_WIDTH(32), .DATA_WIDTH(16), .FIFO_DEPTH(4), .LEN_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_words(num_words), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [15:0] k;
        if (a == 32'h100) return 32'h0001_0009;
        if (a == 32'h104) return 32'h0005_0000;
        if (a == 32'h200) return 32'h0002_0005;
        if (a >= 32'h300 && a < 32'h320) begin
            k = 16'((a - 32'h300) >> 1);
            return {16'hA1 + k, 16'hA0 + k};
        end
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) begin
        #1;
        gnt = random_gnt ? 1'($urandom_range(0, 1)) : def_gnt;
    end

    // One-cycle read latency; inject forces a stray response.
    always @(posedge clk) begin
        rvalid <= (bus.obi_req.req && gnt) || inject;
        rdata  <= inject ? 32'hBEEF_BEEF : mem_rd(bus.obi_req.addr);
    end

    logic [31:0] hs_q[$];
    logic [16:0] pix_q[$];
    int          done_cnt = 0, stab_err = 0, req_cnt = 0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_wait && (!bus.obi_req.req || bus.obi_req.addr != prev_addr)) stab_err++;
            prev_wait = bus.obi_req.req && !gnt;
            prev_addr = bus.obi_req.addr;
            if (bus.obi_req.req) req_cnt++;
            if (bus.obi_req.req && gnt) hs_q.push_back(bus.obi_req.addr);
            if (bus.pixel_valid && pixel_ready) pix_q.push_back({bus.pixel_last, bus.pixel_data});
            if (done) done_cnt++;
        end else begin
            prev_wait = 1'b0;
        end
    end

    task automatic clear_mon();
        hs_q.delete();
        pix_q.delete();
        done_cnt = 0;
        stab_err = 0;
        req_cnt  = 0;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; num_words = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        ncmp++;
        if (!done) begin
            nfail++;
            $display("FAIL %s: done not seen within %0d cycles", nm, budget);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        ncmp++;
        if ({bus.obi_req.req, busy, done, bus.pixel_valid, bus.pixel_last} !== 5'b0) begin
            nfail++;
            $display("FAIL reset_outputs: got req/busy/done/pv/pl=%b want 00000",
                     {bus.obi_req.req, busy, done, bus.pixel_valid, bus.pixel_last});
        end
        ncmp++;
        if ({bus.obi_req.we, bus.obi_req.be, bus.obi_req.wdata} !== {1'b0, 4'hF, 32'h0}) begin
            nfail++;
            $display("FAIL reset_const: got we=%b be=%h wdata=%h want 0 f 0",
                     bus.obi_req.we, bus.obi_req.be, bus.obi_req.wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_two_word(input string nm);
        logic [16:0] exp4 [4];
        exp4 = '{17'h0_0009, 17'h0_0001, 17'h0_0000, 17'h1_0005};
        ncmp++;
        if (hs_q.size() != 2 || hs_q[0] !== 32'h100 || hs_q[1] !== 32'h104) begin
            nfail++;
            $display("FAIL %s_addr: got %0d handshakes first=%h want 2 at 100,104",
                     nm, hs_q.size(), (hs_q.size() > 0) ? hs_q[0] : 32'hx);
        end
        ncmp++;
        if (pix_q.size() != 4) begin
            nfail++;
            $display("FAIL %s_npix: got %0d pixels want 4", nm, pix_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                ncmp++;
                if (pix_q[i] !== exp4[i]) begin
                    nfail++;
                    $display("FAIL %s_pix%0d: got last/data=%h want %h", nm, i, pix_q[i], exp4[i]);
                end
            end
        end
        ncmp++;
        if (done_cnt != 1 || stab_err != 0) begin
            nfail++;
            $display("FAIL %s_done_stab: got done_cnt=%0d stab_err=%0d want 1 0", nm, done_cnt, stab_err);
        end
    endtask

    task automatic test_basic(input bit rnd, input string nm);
        random_gnt = rnd;
        pixel_ready = 1'b1;
        clear_mon();
        do_start(32'h100, 16'd2);
        wait_done(300, nm);
        ncmp++;
        if (busy !== 1'b1) begin
            nfail++;
            $display("FAIL %s_busy_at_done: got %b want 1", nm, busy);
        end
        @(negedge clk);
        ncmp++;
        if ({busy, done} !== 2'b00) begin
            nfail++;
            $display("FAIL %s_busy_after_done: got busy/done=%b want 00", nm, {busy, done});
        end
        repeat (3) @(negedge clk);
        #1;
        check_two_word(nm);
        random_gnt = 1'b0;
    endtask

    task automatic test_backpressure();
        clear_mon();
        @(posedge clk); #1;
        pixel_ready = 1'b0;
        do_start(32'h300, 16'd8);
        repeat (20) @(negedge clk);
        #1;
        ncmp++;
        if (hs_q.size() != 4 || bus.obi_req.req !== 1'b0 || pix_q.size() != 0) begin
            nfail++;
            $display("FAIL bp_credit: got hs=%0d req=%b pix=%0d want 4 0 0",
                     hs_q.size(), bus.obi_req.req, pix_q.size());
        end
        @(posedge clk); #1;
        pixel_ready = 1'b1;
        wait_done(400, "bp");
        #1;
        ncmp++;
        if (hs_q.size() != 8) begin
            nfail++;
            $display("FAIL bp_nhs: got %0d want 8", hs_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                ncmp++;
                if (hs_q[i] !== 32'h300 + 32'(4 * i)) begin
                    nfail++;
                    $display("FAIL bp_addr%0d: got %h want %h", i, hs_q[i], 32'h300 + 32'(4 * i));
                end
            end
        end
        ncmp++;
        if (pix_q.size() != 16) begin
            nfail++;
            $display("FAIL bp_npix: got %0d want 16", pix_q.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                ncmp++;
                if (pix_q[k] !== {k == 15, 16'hA0 + 16'(k)}) begin
                    nfail++;
                    $display("FAIL bp_pix%0d: got %h want %h", k, pix_q[k], {k == 15, 16'hA0 + 16'(k)});
                end
            end
        end
    endtask

    task automatic test_zero_len();
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h0; num_words = 16'd0;
        @(negedge clk);
        ncmp++;
        if (done !== 1'b0) begin
            nfail++;
            $display("FAIL zero_done_early: got %b want 0", done);
        end
        @(posedge clk); #1;
        start = 1'b0;
        // done is high at the second rising edge counting the start edge
        @(negedge clk);
        ncmp++;
        if ({done, busy} !== 2'b11) begin
            nfail++;
            $display("FAIL zero_done: got done/busy=%b want 11", {done, busy});
        end
        @(negedge clk);
        ncmp++;
        if ({done, busy} !== 2'b00 || req_cnt != 0) begin
            nfail++;
            $display("FAIL zero_after: got done/busy=%b req_cycles=%0d want 00 0", {done, busy}, req_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_mon();
        pixel_ready = 1'b1;
        do_start(32'h300, 16'd8);
        while (hs_q.size() < 3 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        ncmp++;
        if (hs_q.size() < 3) begin
            nfail++;
            $display("FAIL rstmid_reach: got %0d handshakes want >=3", hs_q.size());
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        ncmp++;
        if ({bus.obi_req.req, bus.pixel_valid, bus.pixel_last, busy, done} !== 5'b0) begin
            nfail++;
            $display("FAIL rstmid_outputs: got req/pv/pl/busy/done=%b want 00000",
                     {bus.obi_req.req, bus.pixel_valid, bus.pixel_last, busy, done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_mon();
        inject = 1'b1;
        @(posedge clk); #1;
        inject = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ncmp++;
        if ({bus.pixel_valid, busy} !== 2'b00) begin
            nfail++;
            $display("FAIL rstmid_stale: got pv/busy=%b want 00", {bus.pixel_valid, busy});
        end
        do_start(32'h200, 16'd1);
        wait_done(200, "rstmid");
        repeat (2) @(negedge clk);
        #1;
        ncmp++;
        if (hs_q.size() != 1 || pix_q.size() != 2) begin
            nfail++;
            $display("FAIL rstmid_counts: got hs=%0d pix=%0d want 1 2", hs_q.size(), pix_q.size());
        end else begin
            ncmp++;
            if (hs_q[0] !== 32'h200 || pix_q[0] !== 17'h0_0005 || pix_q[1] !== 17'h1_0002) begin
                nfail++;
                $display("FAIL rstmid_data: got addr=%h p0=%h p1=%h want 200 00005 10002",
                         hs_q[0], pix_q[0], pix_q[1]);
            end
        end
    endtask

    task automatic test_restart_busy();
        clear_mon();
        pixel_ready = 1'b1;
        do_start(32'h100, 16'd2);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h200; num_words = 16'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(300, "restart");
        repeat (3) @(negedge clk);
        #1;
        check_two_word("restart");
    endtask

    initial begin
        test_reset();
        test_basic(1'b0, "basic");
        test_basic(1'b1, "rndgnt");
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_restart_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
